// File: rtl/spongent_pkg.sv
// Shared constants, FSM state type and helpers for the Spongent round sequencer.
package spongent_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_IV_DEFAULT = 8'h9E;
  localparam int ROUNDS_DEFAULT = 140;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Mirror a round constant so it can be XORed into the state MSBs.
  function automatic logic [LFSR_W-1:0] bit_rev(input logic [LFSR_W-1:0] v);
    logic [LFSR_W-1:0] r;
    r = '0;
    for (int i = 0; i < LFSR_W; i++) begin
      r[i] = v[LFSR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/lCounter.sv
// LFSR step engine: shifts the word left by one and feeds back the
// x^8+x^4+x^3+x^2+1 tap combination of the low byte into bit 0.
// Callers using an 8-bit LFSR zero-extend it and take out[7:0].
module lCounter (
  input  logic [15:0] in,
  output logic [15:0] out
);

  logic unused_msb;

  assign out        = {in[14:0], in[7] ^ in[3] ^ in[2] ^ in[1]};
  assign unused_msb = in[15];

endmodule

// File: rtl/spongent_round_ctrl.sv
// Spongent permutation round sequencer: accepts a start request, issues one
// round enable per cycle for ROUNDS cycles with the round-constant LFSR and its
// bit-reversed copy, pulses done, then re-arms.
// Optional build macro: SPONGENT_STALL_EN adds stall_i, which freezes a
// running permutation while high.
module spongent_round_ctrl
  import spongent_pkg::*;
#(
  parameter int                ROUNDS  = ROUNDS_DEFAULT,
  parameter logic [LFSR_W-1:0] LFSR_IV = LFSR_IV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SPONGENT_STALL_EN
  input  logic              stall_i,
`endif
  input  logic              start_i,
  output logic              ready_o,
  output logic              load_o,
  output logic              round_en_o,
  output logic [LFSR_W-1:0] lfsr_o,
  output logic [LFSR_W-1:0] lfsr_rev_o,
  output logic [7:0]        round_idx_o,
  output logic              last_round_o,
  output logic              done_o
);

  localparam logic [7:0] LAST_IDX = 8'(ROUNDS - 1);

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_nxt;
  logic [7:0]        idx_q;
  logic [15:0]       lc_out;
  logic [7:0]        unused_lc_hi;
  logic              stall;
  logic              is_last;
  logic              advance;

`ifdef SPONGENT_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  lCounter u_lcounter (
    .in  ({8'h00, lfsr_q}),
    .out (lc_out)
  );

  assign lfsr_nxt     = lc_out[7:0];
  assign unused_lc_hi = lc_out[15:8];

  assign is_last = (idx_q == LAST_IDX);
  assign advance = (state_q == RUN) && !stall;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last round,
  // DONE -> IDLE unconditionally.
  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (advance && is_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs decoded from the current state.
  always_comb begin
    ready_o      = 1'b0;
    load_o       = 1'b0;
    round_en_o   = 1'b0;
    last_round_o = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        load_o  = start_i;
      end
      RUN: begin
        round_en_o   = !stall;
        last_round_o = is_last && !stall;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  // Round constant and round index: step once per executed round, rearm in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_IV;
      idx_q  <= 8'h00;
    end else if (advance) begin
      lfsr_q <= lfsr_nxt;
      idx_q  <= is_last ? 8'h00 : idx_q + 8'h01;
    end else if (state_q == DONE) begin
      lfsr_q <= LFSR_IV;
      idx_q  <= 8'h00;
    end
  end

  assign lfsr_o      = lfsr_q;
  assign lfsr_rev_o  = bit_rev(lfsr_q);
  assign round_idx_o = idx_q;

endmodule
